isqrt_stream: RTL and testbench

- Parametrised sequential integer square root. Computes floor(sqrt(num)) and remainder num - root^2 for an unsigned WIDTH-bit operand.
- Optional round-to-nearest mode, selected per transaction.
- Valid/ready handshake on both input and output, with fixed latency. Sits between stream producers and consumers in the arithmetic datapath.
- Uses the same restoring bit-pair (shift-by-2) algorithm as the existing 16-bit root block, generalised in width and given backpressure and rounding.

---
 rtl/isqrt_stream_if.sv | 32 +++
 rtl/isqrt_stream.sv | 116 +++++++++++
 tb/tb_isqrt_stream.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isqrt_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_stream_if
// Purpose  : Operand/result handshake bundle for the streaming square root.
// Revision : 1.0 - initial release
// ============================================================================
interface isqrt_stream_if #(
  parameter int WIDTH = 32
);
  localparam int RW = WIDTH / 2 + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic             in_round;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    out_root;
  logic [RW-1:0]    out_rem;
  logic             busy;

  modport master (
    output in_valid, in_num, in_round, out_ready,
    input  in_ready, out_valid, out_root, out_rem, busy
  );

  modport slave (
    input  in_valid, in_num, in_round, out_ready,
    output in_ready, out_valid, out_root, out_rem, busy
  );
endinterface
`default_nettype wire

// File: rtl/isqrt_stream.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_stream
// Purpose  : Restoring bit-pair integer square root with optional rounding.
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_stream #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  isqrt_stream_if.slave  bus
);
  localparam int RW      = WIDTH / 2 + 1;
  localparam int c_half  = WIDTH / 2;
  localparam int c_cnt_w = $clog2(c_half) + 1;
  localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(c_half - 1);
  localparam logic [WIDTH-1:0]   c_bit_init = {2'b01, {(WIDTH-2){1'b0}}};

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("isqrt_stream: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_bit;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_round;
  logic                 r_out_valid;
  logic [RW-1:0]        r_out_root;
  logic [RW-1:0]        r_out_rem;
  logic [WIDTH-1:0]     w_trial;
  logic                 w_up;
  logic [RW-1:0]        w_root_fin;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)       w_next = CALC;
      CALC:    if (r_cnt == c_last)    w_next = FIN;
      FIN:                             w_next = DONE;
      DONE:    if (bus.out_ready)      w_next = IDLE;
      default:                         w_next = IDLE;
    endcase
  end

  assign w_trial = r_result + r_bit;
  // Round up when num >= r^2 + r + 1, i.e. the remainder exceeds the floor root.
  assign w_up       = r_round && (r_rem > r_result);
  assign w_root_fin = {1'b0, r_result[c_half-1:0]} + {{(RW-1){1'b0}}, w_up};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem       <= '0;
      r_result    <= '0;
      r_bit       <= '0;
      r_cnt       <= '0;
      r_round     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_root  <= '0;
      r_out_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_rem    <= bus.in_num;
            r_round  <= bus.in_round;
            r_result <= '0;
            r_bit    <= c_bit_init;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          if (r_rem >= w_trial) begin
            r_rem    <= r_rem - w_trial;
            r_result <= (r_result >> 1) + r_bit;
          end else begin
            r_result <= r_result >> 1;
          end
          r_bit <= r_bit >> 2;
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
        FIN: begin
          r_out_rem   <= r_rem[RW-1:0];
          r_out_root  <= w_root_fin;
          r_out_valid <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_root  = r_out_root;
  assign bus.out_rem   = r_out_rem;
endmodule
`default_nettype wire

// File: tb/tb_isqrt_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_isqrt_stream
// Purpose  : Scoreboard bench for isqrt_stream at WIDTH=16 and WIDTH=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isqrt_stream;
  typedef struct {
    longint unsigned root;
    longint unsigned rem;
    longint          acc;
  } exp_t;

  logic   clk;
  logic   rst16;
  logic   rst32;
  logic   rand32;
  int     checks;
  int     errors;
  longint cyc;
  int     acc16;
  int     acc32;
  exp_t   q16[$];
  exp_t   q32[$];

  isqrt_stream_if #(.WIDTH(16)) b16 ();
  isqrt_stream_if #(.WIDTH(32)) b32 ();

  isqrt_stream #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst16), .bus(b16.slave));
  isqrt_stream #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst32), .bus(b32.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  // Reference: nearest integer root when rounding; ties cannot occur since 4n is even.
  function automatic void ref_sqrt(input longint unsigned n, input bit rnd,
                                   output longint unsigned root, output longint unsigned rem);
    longint unsigned r;
    r = 64'($rtoi($sqrt(real'(n))));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    rem  = n - r * r;
    root = (rnd && (4 * n >= (2 * r + 1) * (2 * r + 1))) ? r + 1 : r;
  endfunction

  task automatic send16(input logic [15:0] n, input bit rnd, input int hold);
    longint unsigned er, em;
    int t;
    ref_sqrt(64'(n), rnd, er, em);
    b16.in_valid = 1'b1;
    b16.in_num   = n;
    b16.in_round = rnd;
    t = 0;
    @(negedge clk);
    while (!b16.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!b16.in_ready) begin
      fail_now("send16_accept");
      b16.in_valid = 1'b0;
      return;
    end
    q16.push_back('{er, em, cyc + 1});
    @(posedge clk);
    #1;
    for (int i = 0; i < hold; i++) begin
      b16.in_num = 16'($urandom);
      @(posedge clk);
      #1;
    end
    b16.in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] n, input bit rnd);
    longint unsigned er, em;
    int t;
    ref_sqrt(64'(n), rnd, er, em);
    b32.in_valid = 1'b1;
    b32.in_num   = n;
    b32.in_round = rnd;
    t = 0;
    @(negedge clk);
    while (!b32.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!b32.in_ready) begin
      fail_now("send32_accept");
      b32.in_valid = 1'b0;
      return;
    end
    q32.push_back('{er, em, cyc + 1});
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic drain16();
    int t;
    t = 0;
    while (q16.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (q16.size() != 0) fail_now("drain16");
    #1;
  endtask

  task automatic drain32();
    int t;
    t = 0;
    while (q32.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (q32.size() != 0) fail_now("drain32");
    #1;
  endtask

  initial begin : mon16
    logic pv, pr;
    logic [8:0] proot, prem;
    longint rise;
    exp_t e;
    pv = 1'b0; pr = 1'b0; proot = '0; prem = '0; rise = 0;
    forever begin
      @(negedge clk);
      if (rst16) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("m16_hold_valid", 64'(b16.out_valid), 64'd1);
        check("m16_hold_root", 64'(b16.out_root), 64'(proot));
        check("m16_hold_rem", 64'(b16.out_rem), 64'(prem));
        check("m16_hold_in_ready", 64'(b16.in_ready), 64'd0);
        check("m16_hold_busy", 64'(b16.busy), 64'd1);
      end
      if (b16.out_valid && !pv) rise = cyc;
      if (b16.out_valid && b16.out_ready) begin
        if (q16.size() == 0) begin
          fail_now("m16_unexpected_output");
        end else begin
          e = q16.pop_front();
          check("m16_root", 64'(b16.out_root), 64'(e.root));
          check("m16_rem", 64'(b16.out_rem), 64'(e.rem));
          check("m16_latency", 64'(rise - e.acc), 64'd9);
        end
      end
      pv = b16.out_valid; pr = b16.out_ready;
      proot = b16.out_root; prem = b16.out_rem;
    end
  end

  initial begin : mon32
    logic pv, pr;
    logic [16:0] proot, prem;
    longint rise;
    exp_t e;
    pv = 1'b0; pr = 1'b0; proot = '0; prem = '0; rise = 0;
    forever begin
      @(negedge clk);
      if (rst32) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("m32_hold_valid", 64'(b32.out_valid), 64'd1);
        check("m32_hold_root", 64'(b32.out_root), 64'(proot));
        check("m32_hold_rem", 64'(b32.out_rem), 64'(prem));
        check("m32_hold_in_ready", 64'(b32.in_ready), 64'd0);
      end
      if (b32.out_valid && !pv) rise = cyc;
      if (b32.out_valid && b32.out_ready) begin
        if (q32.size() == 0) begin
          fail_now("m32_unexpected_output");
        end else begin
          e = q32.pop_front();
          check("m32_root", 64'(b32.out_root), 64'(e.root));
          check("m32_rem", 64'(b32.out_rem), 64'(e.rem));
          check("m32_latency", 64'(rise - e.acc), 64'd17);
        end
      end
      pv = b32.out_valid; pr = b32.out_ready;
      proot = b32.out_root; prem = b32.out_rem;
    end
  end

  initial begin
    acc16 = 0;
    acc32 = 0;
    forever begin
      @(negedge clk);
      if (!rst16 && b16.in_valid && b16.in_ready) acc16++;
      if (!rst32 && b32.in_valid && b32.in_ready) acc32++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      b32.out_ready = rand32 ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #1_500_000;
    fail_now("watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    logic [15:0] fl[5];
    logic [15:0] rn[4];
    logic [31:0] n, r;
    int a0, t;
    fl = '{16'd0, 16'd1, 16'd17, 16'd20, 16'd65535};
    rn = '{16'd20, 16'd21, 16'd24, 16'd65535};
    checks = 0; errors = 0; rand32 = 1'b0;
    rst16 = 1'b1; rst32 = 1'b1;
    b16.in_valid = 1'b0; b16.in_num = '0; b16.in_round = 1'b0; b16.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in_num = '0; b32.in_round = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst16 = 1'b0; rst32 = 1'b0;
    @(negedge clk);
    check("rst16_out_valid", 64'(b16.out_valid), 64'd0);
    check("rst16_in_ready", 64'(b16.in_ready), 64'd1);
    check("rst16_busy", 64'(b16.busy), 64'd0);
    check("rst16_root", 64'(b16.out_root), 64'd0);
    check("rst16_rem", 64'(b16.out_rem), 64'd0);
    check("rst32_out_valid", 64'(b32.out_valid), 64'd0);
    check("rst32_in_ready", 64'(b32.in_ready), 64'd1);
    check("rst32_busy", 64'(b32.busy), 64'd0);
    @(posedge clk);
    #1;

    foreach (fl[i]) send16(fl[i], 1'b0, 0);
    drain16();
    foreach (rn[i]) send16(rn[i], 1'b1, 0);
    drain16();

    // Consumer stalls for ten cycles; the monitor checks the held outputs.
    b16.out_ready = 1'b0;
    send16(16'd300, 1'b1, 0);
    t = 0;
    while (!b16.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", 64'(b16.out_valid), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    b16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_valid_drop", 64'(b16.out_valid), 64'd0);
    check("bp_in_ready", 64'(b16.in_ready), 64'd1);
    check("bp_busy", 64'(b16.busy), 64'd0);
    @(posedge clk);
    #1;

    a0 = acc16;
    send16(16'd144, 1'b0, 6);
    drain16();
    check("ignore_accept_once", 64'(acc16 - a0), 64'd1);

    send16(16'd1000, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst16 = 1'b1;
    q16.delete();
    @(posedge clk);
    #1;
    rst16 = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(b16.out_valid), 64'd0);
    check("abort_in_ready", 64'(b16.in_ready), 64'd1);
    check("abort_busy", 64'(b16.busy), 64'd0);
    @(posedge clk);
    #1;
    send16(16'd49, 1'b0, 0);
    drain16();

    rand32 = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 15))
        0:       n = 32'd0;
        1:       n = 32'hFFFF_FFFF;
        2, 3: begin
          r = 32'($urandom_range(0, 65535));
          n = r * r;
        end
        4:       n = 32'($urandom_range(0, 1000));
        default: n = $urandom;
      endcase
      send32(n, 1'($urandom_range(0, 1)));
    end
    drain32();
    rand32 = 1'b0;
    check("sweep_accepts", 64'(acc32), 64'd1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
